// File: rtl/intra_4x4_mode_pred.sv
// Intra 4x4 most-probable-mode context: tracks the current MB's chosen modes,
// the left column of the previous MB and a per-column top line buffer.
module intra_4x4_mode_pred #(
  parameter int PIC_W_MB_LEN = 8,
  parameter int PIC_H_MB_LEN = 8,
  parameter int MB_W_MAX     = 120
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PIC_W_MB_LEN-1:0] mb_x,
  input  logic [PIC_H_MB_LEN-1:0] mb_y,
  input  logic                    mb_start_i,
  output logic                    ready_o,
  input  logic [3:0]              i4x4_num_i,
  output logic [3:0]              i4x4_pred_mode_o,
  input  logic                    i4x4_min_val_i,
  input  logic [3:0]              i4x4_min_mode_i,
  input  logic [3:0]              i4x4_min_num_i,
  input  logic                    mb_done_i,
  input  logic                    mb_is_i4x4_i,
  output logic [63:0]             modes_o,
  output logic                    commit_o
);

  localparam int LB_AW = (MB_W_MAX > 1) ? $clog2(MB_W_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE, S_COMMIT} state_t;

  state_t                  state_q;
  logic [PIC_W_MB_LEN-1:0] mb_x_q;
  logic [PIC_H_MB_LEN-1:0] mb_y_q;
  logic [3:0]              cur_q  [16];
  logic [3:0]              left_q [4];
  logic [3:0]              top_q  [4];
  logic                    ready_q;
  logic                    commit_q;
  logic                    is_i4x4_q;

  logic [15:0]             lbuf [MB_W_MAX];
  logic [15:0]             lb_rd_q;
  logic [15:0]             lb_wdata;
  logic                    lb_re;
  logic                    lb_we;

  // Raster (x,y) inside the MB back to luma4x4BlkIdx.
  function automatic logic [3:0] blk_idx(input logic [1:0] x, input logic [1:0] y);
    return {y[1], x[1], y[0], x[0]};
  endfunction

  assign lb_re = (state_q == S_IDLE) && mb_start_i;
  assign lb_we = (state_q == S_COMMIT);

  always_comb begin
    lb_wdata = '0;
    for (int x = 0; x < 4; x++) begin
      lb_wdata[4*x +: 4] = is_i4x4_q ? cur_q[blk_idx(x[1:0], 2'd3)] : 4'd2;
    end
  end

  // Single-port line buffer: the read (IDLE) and the write (COMMIT) never overlap.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lbuf[mb_x_q[LB_AW-1:0]] <= lb_wdata;
    end else if (lb_re) begin
      lb_rd_q <= lbuf[mb_x[LB_AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mb_x_q    <= '0;
      mb_y_q    <= '0;
      ready_q   <= 1'b0;
      commit_q  <= 1'b0;
      is_i4x4_q <= 1'b0;
      for (int k = 0; k < 16; k++) cur_q[k] <= '0;
      for (int k = 0; k < 4; k++) begin
        left_q[k] <= 4'd2;
        top_q[k]  <= 4'd2;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          commit_q <= 1'b0;
          if (mb_start_i) begin
            mb_x_q  <= mb_x;
            mb_y_q  <= mb_y;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          for (int x = 0; x < 4; x++) top_q[x] <= lb_rd_q[4*x +: 4];
          ready_q <= 1'b1;
          state_q <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (i4x4_min_val_i) cur_q[i4x4_min_num_i] <= i4x4_min_mode_i;
          if (mb_done_i) begin
            is_i4x4_q <= mb_is_i4x4_i;
            commit_q  <= 1'b1;
            state_q   <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          for (int y = 0; y < 4; y++) begin
            left_q[y] <= is_i4x4_q ? cur_q[blk_idx(2'd3, y[1:0])] : 4'd2;
          end
          commit_q <= 1'b0;
          ready_q  <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [1:0] px, py;
  logic [3:0] mode_a, mode_b;
  logic       avail_a, avail_b;

  // Neighbours outside the MB come from left_q/top_q and depend on picture edges.
  always_comb begin
    px      = {i4x4_num_i[2], i4x4_num_i[0]};
    py      = {i4x4_num_i[3], i4x4_num_i[1]};
    mode_a  = left_q[py];
    avail_a = (mb_x_q != '0);
    mode_b  = top_q[px];
    avail_b = (mb_y_q != '0);
    if (px != 2'd0) begin
      mode_a  = cur_q[blk_idx(px - 2'd1, py)];
      avail_a = 1'b1;
    end
    if (py != 2'd0) begin
      mode_b  = cur_q[blk_idx(px, py - 2'd1)];
      avail_b = 1'b1;
    end
    if (avail_a && avail_b) begin
      i4x4_pred_mode_o = (mode_a < mode_b) ? mode_a : mode_b;
    end else begin
      i4x4_pred_mode_o = 4'd2;
    end
  end

  always_comb begin
    modes_o = '0;
    for (int k = 0; k < 16; k++) modes_o[4*k +: 4] = cur_q[k];
  end

  assign ready_o  = ready_q;
  assign commit_o = commit_q;

endmodule

// File: tb/tb_intra_4x4_mode_pred.sv
// Directed bench for intra_4x4_mode_pred: a short picture walk through
// row 0 and row 1 with hand-computed predicted modes and commit results.
module tb_intra_4x4_mode_pred;

  logic        clk;
  logic        rst_n;
  logic [7:0]  mb_x;
  logic [7:0]  mb_y;
  logic        mb_start_i;
  logic        ready_o;
  logic [3:0]  i4x4_num_i;
  logic [3:0]  i4x4_pred_mode_o;
  logic        i4x4_min_val_i;
  logic [3:0]  i4x4_min_mode_i;
  logic [3:0]  i4x4_min_num_i;
  logic        mb_done_i;
  logic        mb_is_i4x4_i;
  logic [63:0] modes_o;
  logic        commit_o;

  int n_tests = 0;
  int n_fail  = 0;

  intra_4x4_mode_pred #(
    .PIC_W_MB_LEN(8),
    .PIC_H_MB_LEN(8),
    .MB_W_MAX(120)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mb_x             (mb_x),
    .mb_y             (mb_y),
    .mb_start_i       (mb_start_i),
    .ready_o          (ready_o),
    .i4x4_num_i       (i4x4_num_i),
    .i4x4_pred_mode_o (i4x4_pred_mode_o),
    .i4x4_min_val_i   (i4x4_min_val_i),
    .i4x4_min_mode_i  (i4x4_min_mode_i),
    .i4x4_min_num_i   (i4x4_min_num_i),
    .mb_done_i        (mb_done_i),
    .mb_is_i4x4_i     (mb_is_i4x4_i),
    .modes_o          (modes_o),
    .commit_o         (commit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_mb(input logic [7:0] x, input logic [7:0] y);
    mb_x = x;
    mb_y = y;
    mb_start_i = 1'b1;
    tick();
    mb_start_i = 1'b0;
    chk("ready_t1", {63'd0, ready_o}, 64'd0);
    tick();
    chk("ready_t2", {63'd0, ready_o}, 64'd1);
  endtask

  task automatic wr(input logic [3:0] num, input logic [3:0] mode);
    i4x4_min_val_i  = 1'b1;
    i4x4_min_num_i  = num;
    i4x4_min_mode_i = mode;
    tick();
    i4x4_min_val_i  = 1'b0;
  endtask

  task automatic pred(input string tag, input logic [3:0] num, input logic [3:0] exp);
    i4x4_num_i = num;
    #1;
    chk(tag, {60'd0, i4x4_pred_mode_o}, {60'd0, exp});
  endtask

  // mb_done pulse; expected modes_o checked in the COMMIT cycle.
  task automatic done_mb(input logic is_i4x4, input logic [63:0] exp_modes, input logic chk_modes);
    mb_done_i    = 1'b1;
    mb_is_i4x4_i = is_i4x4;
    tick();
    mb_done_i    = 1'b0;
    chk("commit_hi", {63'd0, commit_o}, 64'd1);
    if (chk_modes) chk("modes_commit", modes_o, exp_modes);
    tick();
    chk("commit_lo", {63'd0, commit_o}, 64'd0);
    chk("ready_lo_idle", {63'd0, ready_o}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    mb_x = '0; mb_y = '0; mb_start_i = 1'b0;
    i4x4_num_i = '0; i4x4_min_val_i = 1'b0; i4x4_min_mode_i = '0; i4x4_min_num_i = '0;
    mb_done_i = 1'b0; mb_is_i4x4_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_commit", {63'd0, commit_o}, 64'd0);
    chk("rst_modes", modes_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // MB (0,0): every block mode 0.
    start_mb(8'd0, 8'd0);
    for (int k = 0; k < 16; k++) wr(k[3:0], 4'd0);
    pred("a_blk0", 4'd0, 4'd2);
    pred("a_blk1", 4'd1, 4'd2);
    pred("a_blk2", 4'd2, 4'd2);
    pred("a_blk5", 4'd5, 4'd2);
    pred("a_blk3", 4'd3, 4'd0);
    chk("a_commit_pre", {63'd0, commit_o}, 64'd0);
    done_mb(1'b1, 64'h0, 1'b1);

    // MB (0,0) again: right column 8, everything else 1.
    start_mb(8'd0, 8'd0);
    for (int k = 0; k < 16; k++) wr(k[3:0], (k == 5 || k == 7 || k == 13 || k == 15) ? 4'd8 : 4'd1);
    done_mb(1'b1, 64'h8181111181811111, 1'b1);

    // MB (1,0): left column 8 from previous MB, top unavailable.
    start_mb(8'd1, 8'd0);
    pred("c_blk0", 4'd0, 4'd2);
    wr(4'd0, 4'd3);
    pred("c_blk2", 4'd2, 4'd3);
    pred("c_blk1", 4'd1, 4'd2);
    wr(4'd10, 4'd7);
    wr(4'd11, 4'd5);
    wr(4'd14, 4'd6);
    // Last write coincides with mb_done: line word for column 1 becomes 16'h4657.
    i4x4_min_val_i  = 1'b1;
    i4x4_min_num_i  = 4'd15;
    i4x4_min_mode_i = 4'd4;
    mb_done_i       = 1'b1;
    mb_is_i4x4_i    = 1'b1;
    tick();
    i4x4_min_val_i  = 1'b0;
    mb_done_i       = 1'b0;
    chk("c_coinc_commit", {63'd0, commit_o}, 64'd1);
    chk("c_coinc_mode15", {60'd0, modes_o[63:60]}, 64'd4);
    tick();
    chk("c_coinc_commit_lo", {63'd0, commit_o}, 64'd0);

    // MB (0,0) of row 0 once more: bottom row {1,3,4,6}.
    start_mb(8'd0, 8'd0);
    wr(4'd10, 4'd1);
    wr(4'd11, 4'd3);
    wr(4'd14, 4'd4);
    wr(4'd15, 4'd6);
    done_mb(1'b1, 64'h0, 1'b0);

    // MB (0,1): top from line buffer column 0, left unavailable; committed as non-I4x4.
    start_mb(8'd0, 8'd1);
    pred("e_blk0", 4'd0, 4'd2);
    wr(4'd0, 4'd5);
    pred("e_blk1", 4'd1, 4'd3);
    wr(4'd1, 4'd7);
    pred("e_blk4", 4'd4, 4'd4);
    done_mb(1'b0, 64'h0, 1'b0);

    // MB (1,1): left all 2 (non-I4x4 neighbour), top = 16'h4657.
    start_mb(8'd1, 8'd1);
    pred("f_blk0", 4'd0, 4'd2);
    wr(4'd4, 4'd8);
    pred("f_blk5", 4'd5, 4'd4);
    wr(4'd0, 4'd0);
    pred("f_blk1", 4'd1, 4'd0);
    // mb_start in ACTIVE must not relatch mb_y (would make top unavailable).
    mb_x = 8'd0;
    mb_y = 8'd0;
    mb_start_i = 1'b1;
    tick();
    mb_start_i = 1'b0;
    chk("f_ready_hold", {63'd0, ready_o}, 64'd1);
    pred("f_blk5_hold", 4'd5, 4'd4);

    // Asynchronous reset mid-ACTIVE.
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_ready", {63'd0, ready_o}, 64'd0);
    chk("r_modes", modes_o, 64'd0);
    chk("r_commit", {63'd0, commit_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_mb(8'd0, 8'd0);
    pred("r_blk3", 4'd3, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/intra_4x4_mode_pred.md
# intra_4x4_mode_pred

Maintains the intra 4x4 prediction-mode context for the macroblock currently being coded and produces the predicted (most-probable) mode consumed by intra_4x4_top on `i4x4_pred_mode_i`. It captures each final sub-block mode reported on the `i4x4_min_*` outputs and keeps a left-column register set plus a top line buffer covering one picture row of macroblocks. At macroblock end it commits the boundary modes and exports all 16 chosen modes to the entropy coder.

## Interface
- PIC_W_MB_LEN, 8, width of mb_x
- PIC_H_MB_LEN, 8, width of mb_y
- MB_W_MAX, 120, line-buffer depth in macroblocks; mb_x < MB_W_MAX
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- mb_x  in  PIC_W_MB_LEN  current MB column; sampled on mb_start_i
- mb_y  in  PIC_H_MB_LEN  current MB row; sampled on mb_start_i
- mb_start_i  in  1  one-cycle pulse: new MB begins
- ready_o  out  1  context loaded; pred mode valid
- i4x4_num_i  in  4  current sub-block index (luma4x4BlkIdx order)
- i4x4_pred_mode_o  out  4  predicted mode for i4x4_num_i
- i4x4_min_val_i  in  1  final-mode write strobe
- i4x4_min_mode_i  in  4  final mode, 0..8
- i4x4_min_num_i  in  4  sub-block being written
- mb_done_i  in  1  one-cycle pulse: MB mode decision finished
- mb_is_i4x4_i  in  1  MB coded as I4x4 (qualifies mb_done_i)
- modes_o  out  64  16 chosen modes, block k at [4k+3:4k]
- commit_o  out  1  one-cycle pulse: commit complete

## Operation
- Block geometry: x = {num[2],num[0]}, y = {num[3],num[1]}.
- FSM IDLE -> LOAD -> ACTIVE -> COMMIT -> IDLE.
- IDLE: mb_start_i latches mb_x/mb_y, issues line-buffer read at mb_x, -> LOAD. Other inputs ignored.
- LOAD (1 cycle): top_r[0..3] <= line buffer word, -> ACTIVE, ready_o <= 1.
- ACTIVE: i4x4_min_val_i writes cur[i4x4_min_num_i] <= i4x4_min_mode_i. mb_done_i -> COMMIT. mb_start_i ignored.
- COMMIT (1 cycle): if mb_is_i4x4_i latched at mb_done_i is 1: left_r[y] <= cur[x=3,y], line buffer[mb_x] <= {cur[x,3]} for x = 3..0; else left_r and line word all set to 2. commit_o = 1, ready_o <= 0, -> IDLE.
- Line-buffer word: 16 bits, top-row mode x at [4x+3:4x], one word per MB column; single-port, one read or write per cycle.
- Predicted mode (combinational from i4x4_num_i and registers):
  - modeA (left): x > 0 -> cur[x-1,y]; x = 0 -> left_r[y], available only if mb_x > 0.
  - modeB (top): y > 0 -> cur[x,y-1]; y = 0 -> top_r[x], available only if mb_y > 0.
  - Either neighbour unavailable -> pred = 2 (DC); else pred = min(modeA, modeB).
- Internal neighbours are valid because intra_4x4_top finalises blocks in index order; no ordering check is made.
- modes_o mirrors cur; it is held from COMMIT until the next write in the following ACTIVE.
- cur is not cleared at mb_start_i; stale entries are never read before being rewritten.

## Timing
- Reset: state IDLE, ready_o 0, commit_o 0, cur all 0, left_r all 2, top_r all 2, modes_o 0. Line-buffer contents are undefined after reset; row 0 never reads it.
- mb_start_i at cycle T -> ready_o high at T+2.
- i4x4_pred_mode_o: zero latency from i4x4_num_i and from a cur write (visible in the cycle after the strobe).
- Write strobe and mb_done_i in the same cycle: write takes effect; COMMIT uses the updated value.
- mb_done_i at T -> commit_o high at T+1; next mb_start_i accepted from T+2.
- Async reset mid-LOAD/ACTIVE/COMMIT: immediate return to reset values; a partial line-buffer write is not required to be preserved.
- mb_x = 0 ignores left_r; mb_y = 0 ignores top_r. The line buffer is overwritten in place, so row n reads row n-1.

## Test plan
- MB (0,0), all 16 blocks mode 0 -> i4x4_pred_mode_o = 2 for blocks 0, 1, 2, 5 (edges); block 3 = min(0,0) = 0; modes_o = 64'h0.
- MB (1,0) after MB (0,0) with cur[5], cur[7], cur[13], cur[15] = 8 -> block 0 pred = 2 (top unavailable); block 2 (x=0,y=1): left = 8, top = cur[0] -> min.
- MB (0,1) after row 0 where MB (0,0) bottom row = {1,3,4,6} -> block 0 pred = 2 (left unavailable); block 1 (x=1): left cur[0] = 5, top = 3 -> 3.
- MB committed with mb_is_i4x4_i = 0 -> the next MB to the right has left_r = 2; MB (1,1) block 0: left 2, top 7 -> 2.
- Write strobe coincident with mb_done_i (block 15, mode 4) -> line word bits [15:12] = 4; commit_o one cycle later.
- Assert rst_n low during ACTIVE -> ready_o 0 and modes_o 0 immediately; next mb_start_i gives ready_o two cycles later.
